// File: rtl/ebpf_lsu_pkg.sv
// Shared definitions for the eBPF load/store unit.
// Size encodings, FSM states and the size-to-byte-mask helper.
package ebpf_lsu_pkg;

   localparam logic [1:0] SIZE_B  = 2'b00;
   localparam logic [1:0] SIZE_H  = 2'b01;
   localparam logic [1:0] SIZE_W  = 2'b10;
   localparam logic [1:0] SIZE_DW = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } state_t;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      unique case (size)
         SIZE_B:  m = 8'h01;
         SIZE_H:  m = 8'h03;
         SIZE_W:  m = 8'h0f;
         default: m = 8'hff;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction for loads and lane merge for sub-word stores.
// Purely combinational.
module lsu_lane_align
   import ebpf_lsu_pkg::*;
(
   input  logic [63:0] word,
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] merged
);

   logic [7:0]  byte_mask;
   logic [63:0] mask;
   logic [5:0]  shift;

   always_comb begin
      byte_mask = size_mask(size);
      for (int i = 0; i < 8; i++) begin
         mask[i*8 +: 8] = {8{byte_mask[i]}};
      end
      shift     = {offset, 3'b000};
      load_data = (word >> shift) & mask;
      merged    = (word & ~(mask << shift)) | ((wdata & mask) << shift);
   end

endmodule

// File: rtl/ebpf_lsu.sv
// eBPF load/store unit: one request at a time, little-endian,
// sub-word stores by read-modify-write on a 64-bit word memory.
module ebpf_lsu
   import ebpf_lsu_pkg::*;
#(
   parameter int ADDR_SIZE = 5,
   parameter longint unsigned MEM_BYTES = 64'd8 << ADDR_SIZE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_error,
   output logic [63:0] mem_address,
   output logic [63:0] mem_data_in,
   input  logic [63:0] mem_data_out,
   output logic        mem_write_enable
);

   state_t      state_q;
   state_t      state_d;
   logic        write_q;
   logic [1:0]  size_q;
   logic [2:0]  offset_q;
   logic [63:0] wdata_q;
   logic        misaligned;
   logic        out_of_range;
   logic        err;
   logic [63:0] load_data;
   logic [63:0] merged;

   always_comb begin
      misaligned = 1'b0;
      unique case (req_size)
         SIZE_H:  misaligned = req_addr[0];
         SIZE_W:  misaligned = |req_addr[1:0];
         SIZE_DW: misaligned = |req_addr[2:0];
         default: misaligned = 1'b0;
      endcase
      out_of_range = (req_addr >= MEM_BYTES);
      err = misaligned | out_of_range;
   end

   assign req_ready        = (state_q == IDLE);
   assign mem_write_enable = (state_q == WRITE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (err)
                  state_d = RESP;
               else if (req_write && req_size == SIZE_DW)
                  state_d = WRITE;
               else
                  state_d = READ;
            end
         end
         READ:    state_d = write_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   lsu_lane_align u_align (
      .word      (mem_data_out),
      .offset    (offset_q),
      .size      (size_q),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   // The READ-edge capture of mem_data_out lands directly in the
   // load result or the merged store word, whichever is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q     <= 1'b0;
         size_q      <= SIZE_B;
         offset_q    <= 3'd0;
         wdata_q     <= 64'd0;
         mem_address <= 64'd0;
         mem_data_in <= 64'd0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 64'd0;
         rsp_error   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  write_q   <= req_write;
                  size_q    <= req_size;
                  offset_q  <= req_addr[2:0];
                  wdata_q   <= req_wdata;
                  rsp_error <= err;
                  rsp_rdata <= 64'd0;
                  rsp_valid <= err;
                  if (!err) begin
                     mem_address <= 64'({req_addr[ADDR_SIZE+2:3], 2'b00});
                     if (req_write) mem_data_in <= req_wdata;
                  end
               end
            end
            READ: begin
               if (write_q) mem_data_in <= merged;
               else         rsp_rdata   <= load_data;
               rsp_valid <= !write_q;
            end
            WRITE: rsp_valid <= 1'b1;
            RESP:  if (rsp_ready) rsp_valid <= 1'b0;
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/ebpf_lsu.md
# ebpf_lsu

Load/store unit sitting between the eBPF execution core and the data `memory` block. It accepts one LDX/STX-style request at a time (byte, half, word or double-word, little-endian) and drives the memory port (`address`, `data_in`, `write_enable`, `data_out`). Sub-word stores are done as read-modify-write. Each request completes with a response handshake carrying load data or an error flag.

## Interface
Parameters:
- `ADDR_SIZE`, 5, memory word-index width; must equal the memory's `address_size`
- `MEM_BYTES`, 8·2^ADDR_SIZE, derived byte capacity; not overridden

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept (high only in IDLE)
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 B, 01 H, 10 W, 11 DW
- `req_addr`  in  64  byte address
- `req_wdata`  in  64  store data, right-aligned; upper bits ignored
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  core accepts response
- `rsp_rdata`  out  64  load result, zero-extended; 0 for stores and errors
- `rsp_error`  out  1  misaligned or out-of-range access
- `mem_address`  out  64  to memory `address`; value is {word_index, 2'b00}
- `mem_data_in`  out  64  to memory `data_in`
- `mem_data_out`  in  64  from memory `data_out` (combinational read)
- `mem_write_enable`  out  1  to memory `write_enable`

## Operation
- Word index = `req_addr[ADDR_SIZE+2:3]`; byte lane offset = `req_addr[2:0]`; lane shift = offset·8.
- Error at accept if misaligned (H: addr[0]≠0; W: addr[1:0]≠0; DW: addr[2:0]≠0) or `req_addr` ≥ MEM_BYTES. An errored request never touches memory: `mem_write_enable` stays 0.
- States:
  - IDLE: `req_ready`=1. On `req_valid`, latch the request, compute error and word index, then go to:
    - RESP on error
    - READ for a load or a sub-word store
    - WRITE for a DW store
  - READ: `mem_address` holds the word. At the clock edge, capture `mem_data_out` into the word register. Next state is RESP for a load, WRITE for a store.
  - WRITE: `mem_write_enable`=1 for exactly one cycle.
    - DW store: `mem_data_in` = `req_wdata`.
    - Sub-word store: `mem_data_in` = captured word with the size-mask bytes at the lane offset replaced by `req_wdata` low bytes.
    - Next state RESP.
  - RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_error` held stable. Stay until `rsp_ready`, then go to IDLE.
- Load result = (word >> shift) & size mask.
- `mem_address`, `mem_data_in` and `rsp_*` are registered. `mem_write_enable` and `req_ready` are decoded from the state register.

## Timing
- Accept edge = cycle T (`req_valid && req_ready`).
- Load: READ at T+1, `rsp_valid` at T+2.
- DW store: WRITE at T+1, memory updated at the end of T+1, `rsp_valid` at T+2.
- Sub-word store: READ at T+1, WRITE at T+2, `rsp_valid` at T+3.
- Error: `rsp_valid` at T+1.
- `rsp_valid && rsp_ready` in cycle R → `req_ready`=1 at R+1. No accept in the same cycle as the response; throughput is at most one request per 3 cycles.
- `rsp_ready` held low: the response is held indefinitely with no change.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `mem_write_enable`=0, `mem_address`=0, `mem_data_in`=0.
- `rst_n` falling in WRITE: `mem_write_enable` drops immediately (asynchronously). The pending write is lost and no response is issued.
- A request presented while not in IDLE is ignored; the core must hold it until `req_ready`.

## Structure
- Package `ebpf_lsu_pkg` holds:
  - size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`/`SIZE_DW`
  - state enum IDLE/READ/WRITE/RESP
  - a size → byte-mask helper
- Sub-module `lsu_lane_align`, purely combinational, produces the extracted load data and the merged store word from word, offset, size and wdata.

## Test plan
- DW store 0x1122334455667788 to addr 0x10, then DW load from 0x10 → memory word 2 = 0x1122334455667788; `rsp_rdata` same; store `rsp_valid` at T+2.
- After the above, B store 0xAB to addr 0x13 → word 2 = 0x11223344AB667788. Then H load from 0x12 → `rsp_rdata` = 0x000000000000AB66.
- W load from 0x16 (misaligned) → `rsp_error`=1 and `rsp_rdata`=0 at T+1; `mem_write_enable` never asserted.
- Load from 0x100 with ADDR_SIZE=5 (out of range) → `rsp_error`=1. Load from 0xF8 → success.
- Hold `rsp_ready`=0 for 5 cycles after a load → `rsp_valid`/`rsp_rdata` stable; `req_ready`=0 throughout; accept only the cycle after `rsp_ready`=1.
- Assert `rst_n`=0 during WRITE of a B store to 0x08 → word 1 unchanged; all outputs at reset values; a new request is accepted after release.
